// File: rtl/reg_file_sb.sv
// rtl/reg_file_sb.sv - register file with per-register pending (scoreboard) bits; optional forwarding under REG_FILE_BYPASS_EN
module reg_file_sb #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wen0,
  input  logic                  wen1,
  input  logic [ADDR_WIDTH-1:0] waddr0,
  input  logic [ADDR_WIDTH-1:0] waddr1,
  input  logic [DATA_WIDTH-1:0] wdata0,
  input  logic [DATA_WIDTH-1:0] wdata1,
  input  logic [ADDR_WIDTH-1:0] raddr1,
  input  logic [ADDR_WIDTH-1:0] raddr2,
  output logic [DATA_WIDTH-1:0] rdata1,
  output logic [DATA_WIDTH-1:0] rdata2,
  output logic                  rbusy1,
  output logic                  rbusy2,
  input  logic                  set_en,
  input  logic [ADDR_WIDTH-1:0] set_addr,
  output logic [ADDR_WIDTH:0]   busy_cnt
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] regs_q [DEPTH];
  logic [DEPTH-1:0]      pend_q;
  logic [DEPTH-1:0]      pend_d;
  logic [ADDR_WIDTH:0]   busy_cnt_q;
  logic [ADDR_WIDTH:0]   busy_cnt_d;

  // Register 0 is hardwired, so writes and sets aimed at it are dropped here.
  logic wr0_act;
  logic wr1_act;
  logic set_act;

  assign wr0_act = wen0   && (waddr0   != '0);
  assign wr1_act = wen1   && (waddr1   != '0);
  assign set_act = set_en && (set_addr != '0);

  // Next pending vector: writes retire producers, then a new issue re-marks (issue wins).
  always_comb begin
    pend_d = pend_q;
    if (wr0_act) pend_d[waddr0] = 1'b0;
    if (wr1_act) pend_d[waddr1] = 1'b0;
    if (set_act) pend_d[set_addr] = 1'b1;
    pend_d[0] = 1'b0;
  end

  // Count is the population of the next pending vector, so it can never drift from the bits.
  always_comb begin
    busy_cnt_d = '0;
    for (int i = 0; i < DEPTH; i++) begin
      busy_cnt_d = busy_cnt_d + {{ADDR_WIDTH{1'b0}}, pend_d[i]};
    end
  end

  // Pending bits and count; reset empties the scoreboard.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_q     <= '0;
      busy_cnt_q <= '0;
    end else begin
      pend_q     <= pend_d;
      busy_cnt_q <= busy_cnt_d;
    end
  end

  // Register storage; port 1 is written last so it wins a same-address collision.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      if (wr0_act) regs_q[waddr0] <= wdata0;
      if (wr1_act) regs_q[waddr1] <= wdata1;
    end
  end

  assign busy_cnt = busy_cnt_q;

`ifdef REG_FILE_BYPASS_EN
  // Forward same-cycle write data; a forwarded value is complete unless a new producer is issued now.
  function automatic logic [DATA_WIDTH-1:0] rd_data(input logic [ADDR_WIDTH-1:0] a);
    if (a == '0)                     return '0;
    else if (wr1_act && waddr1 == a) return wdata1;
    else if (wr0_act && waddr0 == a) return wdata0;
    else                             return regs_q[a];
  endfunction

  function automatic logic rd_busy(input logic [ADDR_WIDTH-1:0] a);
    if (a == '0)                                               return 1'b0;
    else if ((wr1_act && waddr1 == a) || (wr0_act && waddr0 == a)) return set_act && (set_addr == a);
    else                                                       return pend_q[a];
  endfunction
`else
  // Stored state only; writes show up after the edge.
  function automatic logic [DATA_WIDTH-1:0] rd_data(input logic [ADDR_WIDTH-1:0] a);
    if (a == '0) return '0;
    else         return regs_q[a];
  endfunction

  function automatic logic rd_busy(input logic [ADDR_WIDTH-1:0] a);
    if (a == '0) return 1'b0;
    else         return pend_q[a];
  endfunction
`endif

  // Combinational read ports.
  always_comb begin
    rdata1 = rd_data(raddr1);
    rdata2 = rd_data(raddr2);
    rbusy1 = rd_busy(raddr1);
    rbusy2 = rd_busy(raddr2);
  end

endmodule

// File: tb/tb_reg_file_sb.sv
// tb/tb_reg_file_sb.sv - directed self-checking bench for reg_file_sb
module tb_reg_file_sb;

  logic        clk;
  logic        rst;
  logic        wen0, wen1;
  logic [4:0]  waddr0, waddr1;
  logic [31:0] wdata0, wdata1;
  logic [4:0]  raddr1, raddr2;
  logic [31:0] rdata1, rdata2;
  logic        rbusy1, rbusy2;
  logic        set_en;
  logic [4:0]  set_addr;
  logic [5:0]  busy_cnt;

  int n_checks = 0;
  int n_errors = 0;

  reg_file_sb #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) dut (
    .clk(clk), .rst(rst),
    .wen0(wen0), .wen1(wen1),
    .waddr0(waddr0), .waddr1(waddr1),
    .wdata0(wdata0), .wdata1(wdata1),
    .raddr1(raddr1), .raddr2(raddr2),
    .rdata1(rdata1), .rdata2(rdata2),
    .rbusy1(rbusy1), .rbusy2(rbusy2),
    .set_en(set_en), .set_addr(set_addr),
    .busy_cnt(busy_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wen0 = 0; wen1 = 0; set_en = 0;
  endtask

  task automatic rd(input logic [4:0] a1, input logic [4:0] a2);
    raddr1 = a1; raddr2 = a2;
    #1;
  endtask

  initial begin
    rst = 1; idle();
    waddr0 = 0; waddr1 = 0; wdata0 = 0; wdata1 = 0;
    raddr1 = 0; raddr2 = 0; set_addr = 0;
    step(); step();

    // Reset state across every address
    for (int i = 0; i < 32; i++) begin
      rd(5'(i), 5'(31 - i));
      check($sformatf("rst_rdata1[%0d]", i), rdata1, 32'h0);
      check($sformatf("rst_rbusy2[%0d]", 31 - i), {31'b0, rbusy2}, 32'h0);
    end
    check("rst_busy_cnt", {26'b0, busy_cnt}, 32'h0);
    rst = 0;
    step();

    // Colliding writes on address 3: port 1 wins
    wen0 = 1; waddr0 = 3; wdata0 = 32'hA5A5_0001;
    wen1 = 1; waddr1 = 3; wdata1 = 32'h1234_5678;
    rd(3, 3);
`ifdef REG_FILE_BYPASS_EN
    check("fwd_rdata1_r3", rdata1, 32'h1234_5678);
    check("fwd_rbusy1_r3", {31'b0, rbusy1}, 32'h0);
`else
    check("nofwd_rdata1_r3", rdata1, 32'h0);
`endif
    step(); idle();
    rd(3, 3);
    check("coll_rdata1_r3", rdata1, 32'h1234_5678);
    check("coll_rdata2_r3", rdata2, 32'h1234_5678);

    // Single port 0 write
    wen0 = 1; waddr0 = 4; wdata0 = 32'hCAFE_0004;
    step(); idle();
    rd(3, 4);
    check("p0_rdata2_r4", rdata2, 32'hCAFE_0004);

    // Pend 5, 7, 5 again
    set_en = 1; set_addr = 5; step();
    check("set5_cnt", {26'b0, busy_cnt}, 32'd1);
    set_addr = 7; step();
    check("set7_cnt", {26'b0, busy_cnt}, 32'd2);
    set_addr = 5; step();
    check("reset5_cnt", {26'b0, busy_cnt}, 32'd2);
    idle();
    rd(5, 7);
    check("pend_rbusy1_r5", {31'b0, rbusy1}, 32'h1);
    check("pend_rbusy2_r7", {31'b0, rbusy2}, 32'h1);
    wen0 = 1; waddr0 = 5; wdata0 = 32'h55;
    step(); idle();
    rd(5, 7);
    check("wr5_cnt", {26'b0, busy_cnt}, 32'd1);
    check("wr5_rbusy1", {31'b0, rbusy1}, 32'h0);
    check("wr5_rdata1", rdata1, 32'h55);
    check("wr5_rbusy2_r7", {31'b0, rbusy2}, 32'h1);

    // Set and write the same pending register: stays pending
    set_en = 1; set_addr = 9; step();
    check("set9_cnt", {26'b0, busy_cnt}, 32'd2);
    set_en = 1; set_addr = 9;
    wen1 = 1; waddr1 = 9; wdata1 = 32'h0000_0099;
    step(); idle();
    rd(9, 9);
    check("sw9_rdata1", rdata1, 32'h99);
    check("sw9_rbusy1", {31'b0, rbusy1}, 32'h1);
    check("sw9_cnt", {26'b0, busy_cnt}, 32'd2);

    // Two distinct pending registers retired in one edge: -2
    wen0 = 1; waddr0 = 7; wdata0 = 32'h77;
    wen1 = 1; waddr1 = 9; wdata1 = 32'h9999;
    step(); idle();
    rd(7, 9);
    check("clr2_cnt", {26'b0, busy_cnt}, 32'd0);
    check("clr2_rdata1", rdata1, 32'h77);
    check("clr2_rbusy2", {31'b0, rbusy2}, 32'h0);

    // Both ports hit the same pending register: only -1
    set_en = 1; set_addr = 6; step(); idle();
    check("set6_cnt", {26'b0, busy_cnt}, 32'd1);
    wen0 = 1; waddr0 = 6; wdata0 = 32'h6000;
    wen1 = 1; waddr1 = 6; wdata1 = 32'h6001;
    step(); idle();
    rd(6, 6);
    check("same6_cnt", {26'b0, busy_cnt}, 32'd0);
    check("same6_rdata", rdata1, 32'h6001);

    // Address 0 is inert
    wen0 = 1; waddr0 = 0; wdata0 = 32'hFFFF_FFFF;
    wen1 = 1; waddr1 = 0; wdata1 = 32'hFFFF_FFFF;
    set_en = 1; set_addr = 0;
    rd(0, 0);
    check("r0_same_rdata1", rdata1, 32'h0);
    step(); idle();
    rd(0, 0);
    check("r0_rdata1", rdata1, 32'h0);
    check("r0_rbusy2", {31'b0, rbusy2}, 32'h0);
    check("r0_cnt", {26'b0, busy_cnt}, 32'd0);

    // Pend 1..4, then reset mid-cycle with a write active
    for (int i = 1; i <= 4; i++) begin
      set_en = 1; set_addr = 5'(i); step();
    end
    idle();
    check("pend4_cnt", {26'b0, busy_cnt}, 32'd4);
    wen0 = 1; waddr0 = 10; wdata0 = 32'hDEAD_BEEF;
    #2;
    rst = 1;
    rd(2, 3);
    check("arst_cnt", {26'b0, busy_cnt}, 32'd0);
    check("arst_rbusy1_r2", {31'b0, rbusy1}, 32'h0);
    check("arst_rdata2_r3", rdata2, 32'h0);
    step();
    #2;
    idle();
    rst = 0;
    rd(10, 4);
    check("arst_lost_r10", rdata1, 32'h0);
    check("arst_rdata2_r4", rdata2, 32'h0);

    // First edge after reset release is a normal write
    wen1 = 1; waddr1 = 11; wdata1 = 32'h0000_0011;
    step(); idle();
    rd(11, 10);
    check("post_rst_r11", rdata1, 32'h11);
    check("post_rst_r10", rdata2, 32'h0);
    check("post_rst_cnt", {26'b0, busy_cnt}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/reg_file_sb.md
REG_FILE_SB -- requirements
Module: reg_file_sb

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, register width in bits.
REQ-002 SHALL have parameter ADDR_WIDTH, default 5, register address width; depth is 2**ADDR_WIDTH.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have ports wen0/wen1  input  1 each  write enables, ports 0 and 1.
REQ-006 SHALL have ports waddr0/waddr1  input  ADDR_WIDTH each  write addresses.
REQ-007 SHALL have ports wdata0/wdata1  input  DATA_WIDTH each  write data.
REQ-008 SHALL have ports raddr1/raddr2  input  ADDR_WIDTH each  read addresses.
REQ-009 SHALL have ports rdata1/rdata2  output  DATA_WIDTH each  read data.
REQ-010 SHALL have ports rbusy1/rbusy2  output  1 each  pending flag of the addressed register.
REQ-011 SHALL have port set_en  input  1  marks a register pending (producer issued).
REQ-012 SHALL have port set_addr  input  ADDR_WIDTH  register to mark pending.
REQ-013 SHALL have port busy_cnt  output  ADDR_WIDTH+1  number of pending registers.

Function
REQ-014 Reads SHALL be combinational, zero cycles latency.
REQ-015 Register 0 SHALL read as 0, ignore writes, never be pending; set_en to address 0 is ignored.
REQ-016 A write with wenN=1 to a nonzero address SHALL update that register at the rising edge.
REQ-017 Both ports writing the same nonzero address in one cycle: port 1 data SHALL win.
REQ-018 A write to a register from either port SHALL clear its pending bit at the same edge.
REQ-019 set_en and a write to the same address in one cycle: the pending bit SHALL end set (the new producer wins).
REQ-020 set_en to an already pending register SHALL leave it pending, with no count change.
REQ-021 busy_cnt SHALL be registered and equal the population count of pending bits after each edge; the range is 0 to 2**ADDR_WIDTH-1, with no wrap.
REQ-022 A single edge SHALL change busy_cnt by the net effect: +1 per new set, -1 per distinct cleared register (at most -2).
REQ-023 rbusyN SHALL reflect the pending bit of raddrN, which is 0 for address 0.

Reset
REQ-024 Asserting rst SHALL asynchronously clear all registers, all pending bits and busy_cnt to 0.
REQ-025 While rst is high, writes and set_en SHALL be ignored; a write coincident with reset assertion SHALL be discarded.
REQ-026 After rst falls, the first rising edge SHALL perform normal operation.

Configuration
REQ-027 Macro REG_FILE_BYPASS_EN SHALL control write-to-read forwarding.
REQ-028 With REG_FILE_BYPASS_EN defined, rdataN SHALL return the same-cycle write data when raddrN matches an active nonzero write; port 1 takes priority. rbusyN SHALL read 0 in that case unless set_en targets the same address.
REQ-029 Without REG_FILE_BYPASS_EN, rdataN and rbusyN SHALL return only stored state; same-cycle writes become visible the cycle after the edge.

Verification
REQ-030 Reset then read all addresses -> rdata=0, rbusy=0, busy_cnt=0.
REQ-031 wen0=1 waddr0=3 wdata0=0xA5A5_0001 and wen1=1 waddr1=3 wdata1=0x1234_5678 -> after the edge, reg3=0x1234_5678; with bypass, rdata1 at raddr1=3 is 0x1234_5678 in the same cycle.
REQ-032 set_en to 5, then 7, then 5 -> busy_cnt goes 1,2,2; then wen0 to 5 with wdata0=0x55 -> busy_cnt=1, rbusy(5)=0, reg5=0x55.
REQ-033 Same cycle: set_en to 9 and wen1 to 9 with reg 9 pending -> reg9 is updated, rbusy(9)=1, busy_cnt unchanged.
REQ-034 Write 0xFFFF_FFFF to address 0 and set_en to 0 -> rdata=0, rbusy=0, busy_cnt unchanged.
REQ-035 Pend registers 1 to 4, then assert rst mid-cycle with a write active -> all outputs are 0 immediately and the write is lost.
